// File: rtl/fw_fifo_pkg.sv
// Types and helpers for the framework sync FIFO.
// fifo_status_t bundles the flags; ptr_width sizes the wrap-bit pointers.
package fw_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic ovf;
    logic udf;
  } fifo_status_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/primitives_pkg.sv
// Shared primitive constants for framework blocks.
// Provides single-bit boolean literals TRUE/FALSE.
package primitives_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/fw_fifo_mem.sv
// DEPTH x WIDTH register array, sync write / async read.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
module fw_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset so it maps onto RAM macros.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fw_sync_fifo.sv
// Single-clock first-word-fall-through FIFO, valid/ready both sides.
// Ports: i_clk, i_rst_n, i_clr, i_valid/o_ready/i_data (write),
//        o_valid/i_ready/o_data (read), o_count, o_afull, o_ovf, o_udf.
module fw_sync_fifo
  import fw_fifo_pkg::*;
  import primitives_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12,
  parameter int PW        = ptr_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [PW-1:0]    o_count,
  output logic             o_afull,
  output logic             o_ovf,
  output logic             o_udf
);

  localparam int AW = PW - 1;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] AF_LVL = PW'(AFULL_LVL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fw_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("fw_sync_fifo: AFULL_LVL must be in 1..DEPTH");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          push, pop;
  logic [WIDTH-1:0] rdata;
  fifo_status_t  status;

  // Wrap bit distinguishes full from empty when the indices match.
  assign status.empty = (wr_ptr_q == rd_ptr_q);
  assign status.full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign status.afull = afull_q;
  assign status.ovf   = ovf_q;
  assign status.udf   = udf_q;

  assign o_ready = !status.full;
  assign o_valid = !status.empty;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? ONE : '0);
    rd_ptr_d = rd_ptr_q + (pop ? ONE : '0);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + ONE;
    end else if (pop && !push) begin
      count_d = count_q - ONE;
    end
    // Flag follows the next count so it lines up with o_count.
    afull_d = (count_d >= AF_LVL);
    ovf_d   = ovf_q || (i_valid && status.full);
    udf_d   = udf_q || (i_ready && status.empty);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= FALSE;
      ovf_q    <= FALSE;
      udf_q    <= FALSE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fw_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (push && i_rst_n && !i_clr),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (i_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  // Gate the head word so an empty FIFO shows zero, not stale storage.
  assign o_data  = status.empty ? '0 : rdata;
  assign o_count = count_q;
  assign o_afull = status.afull;
  assign o_ovf   = status.ovf;
  assign o_udf   = status.udf;

endmodule

// File: tb/tb_fw_sync_fifo.sv
// Self-checking bench for fw_sync_fifo against a queue model.
// Directed scenarios followed by a randomized phase.
module tb_fw_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int PW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          i_rst_n, i_clr, i_valid, i_ready;
  logic [W-1:0]  i_data;
  logic          o_ready, o_valid, o_afull, o_ovf, o_udf;
  logic [W-1:0]  o_data;
  logic [PW-1:0] o_count;

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] mq [$];
  bit m_ovf, m_udf;

  fw_sync_fifo #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AFULL_LVL (AF)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count),
    .o_afull (o_afull),
    .o_ovf   (o_ovf),
    .o_udf   (o_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic verify();
    int sz;
    sz = mq.size();
    chk("count", 32'(o_count), 32'(sz));
    chk("valid", 32'(o_valid), 32'(sz > 0));
    chk("ready", 32'(o_ready), 32'(sz < D));
    chk("afull", 32'(o_afull), 32'(sz >= AF));
    chk("ovf", 32'(o_ovf), 32'(m_ovf));
    chk("udf", 32'(o_udf), 32'(m_udf));
    if (sz > 0) chk("head", 32'(o_data), 32'(mq[0]));
  endtask

  // One clock: drive, advance the model by the same edge, then compare.
  task automatic cyc(input bit rst, input bit clr, input bit v,
                     input logic [W-1:0] d, input bit r);
    bit full, empty;
    i_rst_n = !rst;
    i_clr   = clr;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    full  = (mq.size() == D);
    empty = (mq.size() == 0);
    @(posedge clk);
    if (rst || clr) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (v && full) m_ovf = 1;
      if (r && empty) m_udf = 1;
      if (r && !empty) void'(mq.pop_front());
      if (v && !full) mq.push_back(d);
    end
    #1;
    verify();
  endtask

  initial begin
    logic [W-1:0] exp_rd;
    i_rst_n = 1'b0;
    i_clr   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;

    // Reset held 3 cycles with a write request pending.
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'hEE, 0);
    chk("rst_data", 32'(o_data), 32'h0);

    // Fill 0x01..0x10 with consumer stalled.
    for (int i = 1; i <= D; i++) begin
      cyc(0, 0, 1, W'(i), 0);
      if (i == AF - 1) chk("afull_below", 32'(o_afull), 32'h0);
      if (i == AF) chk("afull_at", 32'(o_afull), 32'h1);
    end
    chk("full_ovf_clear", 32'(o_ovf), 32'h0);

    // Push into a full FIFO: dropped, overflow sticks.
    cyc(0, 0, 1, 8'hAA, 0);
    chk("ovf_set", 32'(o_ovf), 32'h1);

    // Drain and check order 0x01..0x10.
    for (int i = 1; i <= D; i++) begin
      exp_rd = W'(i);
      chk("drain", 32'(o_data), 32'(exp_rd));
      cyc(0, 0, 0, 8'h00, 1);
    end
    chk("drained", 32'(o_valid), 32'h0);

    // Streaming: one word primed, then push+pop every cycle.
    cyc(1, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h00, 0);
    for (int i = 1; i <= 100; i++) begin
      exp_rd = W'(i - 1);
      chk("stream_head", 32'(o_data), 32'(exp_rd));
      cyc(0, 0, 1, W'(i), 1);
      chk("stream_cnt", 32'(o_count), 32'h1);
    end
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 8'h00, 1);

    // Underflow, then 1-cycle fall-through.
    cyc(0, 0, 0, 8'h00, 1);
    chk("udf_set", 32'(o_udf), 32'h1);
    cyc(0, 0, 1, 8'h5C, 0);
    chk("ft_valid", 32'(o_valid), 32'h1);
    chk("ft_data", 32'(o_data), 32'h5C);

    // Flush with 7 entries, clear wins over push and pop.
    cyc(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, W'(8'h40 + i), 0);
    cyc(0, 0, 1, 8'h00, 1);
    cyc(0, 1, 1, 8'h77, 1);
    chk("clr_cnt", 32'(o_count), 32'h0);
    chk("clr_valid", 32'(o_valid), 32'h0);
    cyc(0, 0, 1, 8'h33, 0);
    chk("clr_next", 32'(o_data), 32'h33);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      cyc(0, ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
          W'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 300; i++) begin
      cyc(0, 0, $urandom_range(0, 3) != 0, W'($urandom),
          $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
